axil_param_regbank: RTL and testbench
=====================================

// Module: axil_param_regbank
// PURPOSE
// - AXI4-Lite slave register bank; parametrised successor of the fixed 4-register 32-bit peripheral.
// - Configurable register count, data width and read-only map; byte strobes; SLVERR on bad access.
// - Decoupled AW/W acceptance; per-register write pulse. Sits behind the AXI interconnect in the BD.
// PARAMETERS
// - C_DATA_WIDTH   32            data bus width, 32 or 64
// - C_NUM_REGS     16            number of registers, 1..64
// - C_ADDR_WIDTH   8             AXI address width; must cover C_NUM_REGS*(C_DATA_WIDTH/8) bytes
// - C_RO_MASK      '0            bit n=1: register n is read-only, value taken from reg_in
// PORTS
// - ACLK          in   1                     clock, all logic on rising edge
// - ARESETN       in   1                     asynchronous active-low reset
// - S_AXI_AW*     in/out  ADDR,PROT,VALID,READY  write address channel
// - S_AXI_W*      in/out  DATA,STRB,VALID,READY  write data channel (STRB = C_DATA_WIDTH/8)
// - S_AXI_B*      out/in  RESP[1:0],VALID,READY  write response channel
// - S_AXI_AR*     in/out  ADDR,PROT,VALID,READY  read address channel
// - S_AXI_R*      out/in  DATA,RESP[1:0],VALID,READY  read data channel
// - reg_out       out  C_NUM_REGS*C_DATA_WIDTH  flattened register contents, reg n at [n*W +: W]
// - reg_in        in   C_NUM_REGS*C_DATA_WIDTH  values returned for read-only registers
// - wr_pulse      out  C_NUM_REGS            one-cycle strobe when register n is written
// BEHAVIOUR
// - Reset (ARESETN low, async): all registers 0; all READY/VALID 0; RESP/RDATA 0; wr_pulse 0.
// - Index = ADDR >> log2(C_DATA_WIDTH/8); low address bits ignored; PROT ignored.
// - Write FSM: W_IDLE -> (capture AW and/or W in independent holding regs) -> W_RESP.
//   - AWREADY high while AW holding reg empty and no B pending; same rule for WREADY/W.
//   - AW and W may arrive in either order or same cycle; commit in the cycle both are held.
//   - Commit: byte lanes with WSTRB=1 updated; wr_pulse[idx]=1 that cycle; BVALID rises next cycle.
//   - BVALID held until BREADY; no new AW/W accepted while BVALID=1 (one outstanding write).
//   - Index >= C_NUM_REGS: no update, no pulse, BRESP=2'b10. RO register: no update, BRESP=2'b10.
// - Read path: ARREADY high when RVALID=0 and no AR held; RVALID one cycle after AR handshake.
//   - RDATA = reg_in slice for RO regs, stored value otherwise; RRESP=2'b00.
//   - Index >= C_NUM_REGS: RDATA=0, RRESP=2'b10. RDATA/RRESP stable while RVALID && !RREADY.
// - Simultaneous read and write commit to the same register: read returns pre-write value.
// - Read and write paths independent; one outstanding transaction each.
// - WSTRB=0 write to valid RW reg: OKAY response, no data change, wr_pulse still asserted.
// - Reset mid-transaction: in-flight transfer discarded, no B/R issued after reset release.
// STRUCTURE
// - Shared package axil_pkg: localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10; typedef of write FSM.
// - No sub-module: a single file holding write FSM, read path and register array.
// - Byte-merge function (old, new, strb) placed in axil_pkg for reuse by other slaves.
// TESTING
// - Write 0x1..0x4 to addr 0x0,0x4,0x8,0xC, read back -> data equal, RESP OKAY each.
// - W sent 3 cycles before AW to 0x10, data 0xDEADBEEF -> BRESP OKAY, readback 0xDEADBEEF.
// - Reg 2 = 0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
// - Write/read addr 0x40 with C_NUM_REGS=16 -> BRESP 2'b10 and RRESP 2'b10, RDATA 0, no pulse.
// - C_RO_MASK bit 1 set, reg_in[1]=0xA5A5A5A5, write 0x12345678 to 0x4 -> BRESP 2'b10, read 0xA5A5A5A5.
// - Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and payload stable; AWREADY=0 throughout.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite slave response codes, write FSM type and byte-merge helper
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  // Callers narrower than 64 bits zero-pad the inputs and truncate the result.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_val,
    input logic [MAX_DATA_WIDTH-1:0] new_val,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_param_regbank_if.sv
// rtl/axil_param_regbank_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_param_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_param_regbank.sv
// rtl/axil_param_regbank.sv - AXI4-Lite register bank with byte strobes, read-only map and write pulses
module axil_param_regbank
  import axil_pkg::*;
#(
  parameter int          C_DATA_WIDTH = 32,
  parameter int          C_NUM_REGS   = 16,
  parameter int          C_ADDR_WIDTH = 8,
  parameter logic [63:0] C_RO_MASK    = '0
) (
  input  logic                               aclk_i,
  input  logic                               aresetn_i,
  axil_param_regbank_if.slave                s_axi,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out_o,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_in_i,
  output logic [C_NUM_REGS-1:0]              wr_pulse_o
);

  localparam int STRB_W   = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
  localparam int SEL_W    = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [C_NUM_REGS-1:0] RO_MASK = C_RO_MASK[C_NUM_REGS-1:0];

  logic                    rst_done_q;
  wr_state_e               state_q, state_d;

  logic                    aw_full_q;
  logic [IDX_W-1:0]        aw_idx_q;
  logic                    w_full_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [1:0]              bresp_q;

  logic                    rvalid_q;
  logic [C_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]              rresp_q;

  logic [C_DATA_WIDTH-1:0] regs_q     [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] reg_in_arr [C_NUM_REGS];

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs;
  logic             commit, wr_ok;
  logic [SEL_W-1:0] aw_sel, ar_sel;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_in_range, ar_in_range, aw_ro, ar_ro;
  logic             unused_bits;

  for (genvar n = 0; n < C_NUM_REGS; n++) begin : g_flat
    assign reg_out_o[n*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[n];
    assign reg_in_arr[n] = reg_in_i[n*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Sub-word address bits and PROT carry no meaning for this bank.
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  assign aw_sel      = SEL_W'(aw_idx_q);
  assign aw_in_range = int'(aw_idx_q) < C_NUM_REGS;
  assign aw_ro       = RO_MASK[aw_sel];
  assign wr_ok       = aw_in_range && !aw_ro;

  assign ar_idx      = s_axi.araddr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_sel      = SEL_W'(ar_idx);
  assign ar_in_range = int'(ar_idx) < C_NUM_REGS;
  assign ar_ro       = RO_MASK[ar_sel];

  assign aw_hs = s_axi.awvalid && awready;
  assign w_hs  = s_axi.wvalid && wready;
  assign ar_hs = s_axi.arvalid && arready;

  // Holds every READY low while reset is asserted and for the first edge after release.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    awready    = 1'b0;
    wready     = 1'b0;
    commit     = 1'b0;
    wr_pulse_o = '0;
    case (state_q)
      W_IDLE: begin
        awready = rst_done_q && !aw_full_q;
        wready  = rst_done_q && !w_full_q;
        if (aw_full_q && w_full_q) begin
          commit  = 1'b1;
          state_d = W_RESP;
          if (wr_ok) begin
            wr_pulse_o[aw_sel] = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi.awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int n = 0; n < C_NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
    end else if (commit && wr_ok) begin
      regs_q[aw_sel] <= C_DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(regs_q[aw_sel]),
                                                 MAX_DATA_WIDTH'(wdata_q),
                                                 MAX_STRB_WIDTH'(wstrb_q)));
    end
  end

  // Read data is captured at the AR handshake, so a write committing on the same edge is not yet visible.
  assign arready = rst_done_q && !rvalid_q;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (!ar_in_range) begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end else begin
        rdata_q <= ar_ro ? reg_in_arr[ar_sel] : regs_q[ar_sel];
        rresp_q <= RESP_OKAY;
      end
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = (state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axil_param_regbank.sv
// tb/tb_axil_param_regbank.sv - directed vector bench for axil_param_regbank
`timescale 1ns/1ps
module tb_axil_param_regbank;
  import axil_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NR  = 16;
  localparam int TMO = 50;
  localparam int NV  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          sel = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;

  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  logic [NR*DW-1:0] reg_out0, reg_out1, reg_in0, reg_in1;
  logic [NR-1:0]    pulse0, pulse1, pulse, pulse_seen;
  logic             pulse_clr = 1'b1;

  axil_param_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 (), if1 ();

  assign if0.awaddr = awaddr;   assign if1.awaddr = awaddr;
  assign if0.awprot = 3'b010;   assign if1.awprot = 3'b010;
  assign if0.awvalid = awvalid; assign if1.awvalid = awvalid;
  assign if0.wdata = wdata;     assign if1.wdata = wdata;
  assign if0.wstrb = wstrb;     assign if1.wstrb = wstrb;
  assign if0.wvalid = wvalid;   assign if1.wvalid = wvalid;
  assign if0.bready = bready;   assign if1.bready = bready;
  assign if0.araddr = araddr;   assign if1.araddr = araddr;
  assign if0.arprot = 3'b001;   assign if1.arprot = 3'b001;
  assign if0.arvalid = arvalid; assign if1.arvalid = arvalid;
  assign if0.rready = rready;   assign if1.rready = rready;

  assign awready = sel ? if1.awready : if0.awready;
  assign wready  = sel ? if1.wready  : if0.wready;
  assign bvalid  = sel ? if1.bvalid  : if0.bvalid;
  assign bresp   = sel ? if1.bresp   : if0.bresp;
  assign arready = sel ? if1.arready : if0.arready;
  assign rvalid  = sel ? if1.rvalid  : if0.rvalid;
  assign rdata   = sel ? if1.rdata   : if0.rdata;
  assign rresp   = sel ? if1.rresp   : if0.rresp;
  assign pulse   = sel ? pulse1      : pulse0;

  assign reg_in0 = {NR{32'h5A5A_5A5A}};
  assign reg_in1 = {{(NR-2)*DW{1'b0}}, 32'hA5A5_A5A5, 32'h0000_0000};

  axil_param_regbank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW), .C_RO_MASK(64'h0)) dut0 (
    .aclk_i(clk), .aresetn_i(rst_n), .s_axi(if0),
    .reg_out_o(reg_out0), .reg_in_i(reg_in0), .wr_pulse_o(pulse0)
  );

  axil_param_regbank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW), .C_RO_MASK(64'h2)) dut1 (
    .aclk_i(clk), .aresetn_i(rst_n), .s_axi(if1),
    .reg_out_o(reg_out1), .reg_in_i(reg_in1), .wr_pulse_o(pulse1)
  );

  always @(posedge clk) begin
    if (pulse_clr) pulse_seen <= '0;
    else           pulse_seen <= pulse_seen | pulse;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: still running at 500 us, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within %0d cycles, expected one", name, TMO);
  endtask

  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("aw_handshake");
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("w_handshake");
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [AW-1:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("ar_handshake");
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp);
    int n = 0;
    fork
      drive_aw(a, (lead > 0) ? lead : 0);
      drive_w(d, s, (lead < 0) ? -lead : 0);
    join
    bready = 1'b1;
    while (!bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("b_wait");
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    int n = 0;
    drive_ar(a);
    rready = 1'b1;
    while (!rvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout_fail("r_wait");
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    int            lead;
    logic [1:0]    exp_bresp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;
    logic [NR-1:0] exp_pulse;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [1:0]    resp_b, resp_r;
    logic [DW-1:0] rd;
    logic          bad;
    int            idx;

    vecs[0]  = '{1'b0, 8'h00, 32'h0000_0001, 4'hF,  0, RESP_OKAY,   32'h0000_0001, RESP_OKAY,   16'h0001};
    vecs[1]  = '{1'b0, 8'h04, 32'h0000_0002, 4'hF,  0, RESP_OKAY,   32'h0000_0002, RESP_OKAY,   16'h0002};
    vecs[2]  = '{1'b0, 8'h08, 32'h0000_0003, 4'hF,  0, RESP_OKAY,   32'h0000_0003, RESP_OKAY,   16'h0004};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0000_0004, 4'hF,  0, RESP_OKAY,   32'h0000_0004, RESP_OKAY,   16'h0008};
    vecs[4]  = '{1'b0, 8'h10, 32'hDEAD_BEEF, 4'hF,  3, RESP_OKAY,   32'hDEAD_BEEF, RESP_OKAY,   16'h0010};
    vecs[5]  = '{1'b0, 8'h08, 32'hFFFF_FFFF, 4'hF,  0, RESP_OKAY,   32'hFFFF_FFFF, RESP_OKAY,   16'h0004};
    vecs[6]  = '{1'b0, 8'h08, 32'h0000_0000, 4'h5,  0, RESP_OKAY,   32'hFF00_FF00, RESP_OKAY,   16'h0004};
    vecs[7]  = '{1'b0, 8'h08, 32'h1234_5678, 4'h0,  0, RESP_OKAY,   32'hFF00_FF00, RESP_OKAY,   16'h0004};
    vecs[8]  = '{1'b0, 8'h40, 32'h1111_1111, 4'hF,  0, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR, 16'h0000};
    vecs[9]  = '{1'b1, 8'h04, 32'h1234_5678, 4'hF,  0, RESP_SLVERR, 32'hA5A5_A5A5, RESP_OKAY,   16'h0000};
    vecs[10] = '{1'b0, 8'h0E, 32'h0000_0011, 4'hF,  0, RESP_OKAY,   32'h0000_0011, RESP_OKAY,   16'h0008};
    vecs[11] = '{1'b0, 8'h3C, 32'hCAFE_F00D, 4'hF, -2, RESP_OKAY,   32'hCAFE_F00D, RESP_OKAY,   16'h8000};

    repeat (3) @(negedge clk);
    check("rst_ready", {61'd0, awready, wready, arready}, 64'h0);
    check("rst_valid", {62'd0, bvalid, rvalid}, 64'h0);
    check("rst_payload", {28'd0, bresp, rresp, rdata}, 64'h0);
    check("rst_regs_nonzero", {63'd0, |reg_out0}, 64'h0);
    check("rst_pulse", {48'd0, pulse0}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {61'd0, awready, wready, arready}, 64'h7);
    pulse_clr = 1'b0;

    for (int i = 0; i < NV; i++) begin
      sel = vecs[i].sel;
      pulse_clr = 1'b1;
      @(negedge clk);
      pulse_clr = 1'b0;
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, resp_b);
      check($sformatf("v%0d_bresp", i), {62'd0, resp_b}, {62'd0, vecs[i].exp_bresp});
      check($sformatf("v%0d_pulse", i), {48'd0, pulse_seen}, {48'd0, vecs[i].exp_pulse});
      if (!vecs[i].sel && vecs[i].exp_bresp == RESP_OKAY) begin
        idx = int'(vecs[i].addr >> 2);
        check($sformatf("v%0d_reg_out", i), {32'd0, reg_out0[idx*DW +: DW]}, {32'd0, vecs[i].exp_rdata});
      end
      axi_read(vecs[i].addr, rd, resp_r);
      check($sformatf("v%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_rresp", i), {62'd0, resp_r}, {62'd0, vecs[i].exp_rresp});
    end
    sel = 1'b0;

    // Back-pressure on B and R: responses must hold and no new address may be taken.
    fork
      drive_aw(8'h14, 0);
      drive_w(32'h0000_0055, 4'hF, 0);
    join
    idx = 0;
    while (!bvalid && idx < TMO) begin @(negedge clk); idx++; end
    for (int c = 0; c < 10; c++) begin
      awvalid = 1'b1;
      check($sformatf("b_stall_%0d", c), {59'd0, bvalid, bresp, awready, wready}, {59'd0, 1'b1, RESP_OKAY, 1'b0, 1'b0});
      @(negedge clk);
    end
    awvalid = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_released", {63'd0, bvalid}, 64'h0);

    drive_ar(8'h14);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("r_stall_%0d", c), {28'd0, rvalid, rresp, rdata, arready}, {28'd0, 1'b1, RESP_OKAY, 32'h0000_0055, 1'b0});
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("r_released", {63'd0, rvalid}, 64'h0);

    // Read handshake on the same edge as a write commit returns the old value.
    axi_write(8'h18, 32'h0000_1111, 4'hF, 0, resp_b);
    awaddr = 8'h18; awvalid = 1'b1; wdata = 32'h0000_2222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h18; arvalid = 1'b1;
    check("same_commit_pulse", {48'd0, pulse0}, 64'h0040);
    @(negedge clk);
    arvalid = 1'b0;
    check("same_rvalid_bvalid", {62'd0, rvalid, bvalid}, 64'h3);
    check("same_rdata_old", {32'd0, rdata}, 64'h0000_1111);
    check("same_reg_new", {32'd0, reg_out0[6*DW +: DW]}, 64'h0000_2222);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h18, rd, resp_r);
    check("same_readback_new", {32'd0, rd}, 64'h0000_2222);

    // Reset with a write held and a read response pending.
    awaddr = 8'h1C; awvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 8'h00; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_async_clear", {62'd0, bvalid, rvalid}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bad = bad | bvalid | rvalid | (|pulse0);
    end
    check("midrst_no_resp", {63'd0, bad}, 64'h0);
    axi_read(8'h1C, rd, resp_r);
    check("midrst_write_dropped", {32'd0, rd}, 64'h0);
    axi_read(8'h00, rd, resp_r);
    check("midrst_regs_cleared", {32'd0, rd}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
